// File: rtl/data_register_file.sv
// -----------------------------------------------------------------------------
// data_register_file
//   Parametrised single-clock register file (DEPTH = 2**ADDR_W words of DATA_W
//   bits). It has one write port and one registered read port with a one-cycle
//   read-valid pulse. When a read and a write hit the same address in the same
//   cycle, the read returns the new write data (write-first bypass). A clear
//   sequencer zeroes every entry after reset, and again whenever clear_req is
//   seen while the array is ready.
//
//   Optional feature macro: DATA_REG_PARITY_EN
//     defined   : each entry carries an even-parity bit; parity_inject stores
//                 inverted parity; read_parity_err flags a mismatch on reads.
//     undefined : plain DATA_W storage; parity_inject is ignored;
//                 read_parity_err is constant 0.
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   clear_req       in   restart the clear sequence (only honoured when ready)
//   ready           out  1 = array usable, 0 while clearing
//   write_en        in   write strobe
//   write_addr      in   write index  [ADDR_W]
//   write_data      in   write word   [DATA_W]
//   read_en         in   read request
//   read_addr       in   read index   [ADDR_W]
//   read_data       out  read word    [DATA_W], valid when read_valid=1
//   read_valid      out  one-cycle pulse, 1 cycle after an accepted read
//   parity_inject   in   with write_en: store inverted parity
//   read_parity_err out  parity mismatch on read_data (qualified by read_valid)
// -----------------------------------------------------------------------------
module data_register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              ready,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic              parity_inject,
  output logic              read_parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DATA_REG_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_perr_q, rd_perr_d;

  // Storage is intentionally not reset; the clear sequencer owns initialisation.
  logic [WORD_W-1:0]   mem_q [0:DEPTH-1];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;

  logic [WORD_W-1:0]   wr_word;
  logic [WORD_W-1:0]   rd_word;
  logic                rd_hit;
  logic                rd_perr;
  logic                rd_accept;

  assign ready     = (state_q == ST_READY);
  assign rd_accept = ready & read_en;
  assign rd_hit    = write_en & (write_addr == read_addr);

`ifdef DATA_REG_PARITY_EN
  // Even parity: the stored bit makes the XOR of all WORD_W bits zero.
  assign wr_word = {(^write_data) ^ parity_inject, write_data};
  // A bypassed read carries freshly computed parity, so it never flags.
  assign rd_perr = rd_hit ? 1'b0 : (^rd_word);
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign wr_word = write_data;
  assign rd_perr = 1'b0;
`endif

  assign rd_word = rd_hit ? wr_word : mem_q[read_addr];

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (&ptr_q) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory write port: the sequencer owns it while clearing, the user otherwise.
  // An all-zero word already has correct even parity.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (write_en) begin
      mem_we    = 1'b1;
      mem_waddr = write_addr;
      mem_wdata = wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port; read_data holds between accepted reads.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_perr_d  = 1'b0;
    if (rd_accept) begin
      rd_data_d  = rd_word[DATA_W-1:0];
      rd_valid_d = 1'b1;
      rd_perr_d  = rd_perr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_perr_q  <= rd_perr_d;
    end
  end

  assign read_data       = rd_data_q;
  assign read_valid      = rd_valid_q;
  assign read_parity_err = rd_perr_q;

endmodule

// File: tb/tb_data_register_file.sv
module tb_data_register_file;

`ifdef DATA_REG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear_req = 1'b0;
  logic       ready;
  logic       write_en = 1'b0;
  logic [7:0] write_addr = '0;
  logic [7:0] write_data = '0;
  logic       read_en = 1'b0;
  logic [7:0] read_addr = '0;
  logic [7:0] read_data;
  logic       read_valid;
  logic       parity_inject = 1'b0;
  logic       read_parity_err;

  always #5 clock = ~clock;

  data_register_file #(.DATA_W(8), .ADDR_W(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .clear_req      (clear_req),
    .ready          (ready),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .read_en        (read_en),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .parity_inject  (parity_inject),
    .read_parity_err(read_parity_err)
  );

  // Reference model: plain array of contents plus per-entry "bad parity" flag.
  logic [7:0] ref_mem [256];
  bit         ref_bad [256];
  bit         model_ready = 1'b0;
  int         clr_cnt = 0;
  logic [7:0] last_data = '0;
  logic [8:0] exp_q [$];   // {expected parity_err, expected data}

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model on every falling edge.
  always @(negedge clock) begin
    logic [8:0] e;
    check("ready", {31'b0, ready}, {31'b0, model_ready});
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_valid", {31'b0, read_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("read_data", {24'b0, read_data}, {24'b0, e[7:0]});
        check("read_parity_err", {31'b0, read_parity_err}, {31'b0, e[8]});
        last_data = e[7:0];
      end
    end else begin
      if (exp_q.size() != 0) begin
        check("read_valid_missing", {31'b0, read_valid}, 32'd1);
        e = exp_q.pop_front();
      end
      check("read_data_hold", {24'b0, read_data}, {24'b0, last_data});
    end
  end

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic cycle(input bit we, input logic [7:0] wa, input logic [7:0] wd,
                       input bit re, input logic [7:0] ra, input bit cr, input bit pi);
    bit hit;
    write_en = we; write_addr = wa; write_data = wd;
    read_en = re; read_addr = ra; clear_req = cr; parity_inject = pi;
    @(posedge clock);
    if (reset_n) begin
      if (model_ready) begin
        if (re) begin
          hit = we && (wa == ra);
          exp_q.push_back({PAR_EN && !hit && ref_bad[ra], hit ? wd : ref_mem[ra]});
        end
        if (we) begin
          ref_mem[wa] = wd;
          ref_bad[wa] = PAR_EN && pi;
        end
        if (cr) begin
          model_ready = 1'b0;
          clr_cnt = 0;
        end
      end else begin
        ref_mem[clr_cnt] = 8'h00;
        ref_bad[clr_cnt] = 1'b0;
        clr_cnt++;
        if (clr_cnt == 256) model_ready = 1'b1;
      end
    end
    #1;
    write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0; parity_inject = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit pi);
    cycle(1'b1, a, d, 1'b0, 8'h00, 1'b0, pi);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !model_ready; i++) idle();
  endtask

  // Asynchronous reset: outputs must drop immediately, before any clock edge.
  task automatic apply_reset(input int hold);
    reset_n = 1'b0;
    exp_q.delete();
    model_ready = 1'b0;
    clr_cnt = 0;
    last_data = '0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("rst_read_data", {24'b0, read_data}, 32'd0);
    check("rst_parity_err", {31'b0, read_parity_err}, 32'd0);
    repeat (hold) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    apply_reset(1);

    // Initial clear, then read of a mid-array entry.
    wait_ready();
    rd(8'h7F);
    idle();

    // Back-to-back reads after three writes.
    wr(8'h00, 8'h04, 1'b0);
    wr(8'h01, 8'h05, 1'b0);
    wr(8'h02, 8'h06, 1'b0);
    rd(8'h00);
    rd(8'h01);
    rd(8'h02);
    idle();

    // Same-cycle write and read to one address: bypass.
    cycle(1'b1, 8'h10, 8'hA5, 1'b1, 8'h10, 1'b0, 1'b0);
    idle();
    rd(8'h10);
    idle();

    // Clear request wipes data; writes while clearing are lost.
    wr(8'hFF, 8'h3C, 1'b0);
    cycle(1'b1, 8'h20, 8'h99, 1'b1, 8'hFF, 1'b1, 1'b0);
    wr(8'hFF, 8'h77, 1'b0);
    rd(8'hFF);
    wait_ready();
    rd(8'hFF);
    rd(8'h20);
    idle();

    // Parity inject and repair.
    wr(8'h05, 8'h81, 1'b1);
    rd(8'h05);
    wr(8'h05, 8'h81, 1'b0);
    rd(8'h05);
    wr(8'h06, 8'h7E, 1'b1);
    cycle(1'b1, 8'h06, 8'h7E, 1'b1, 8'h06, 1'b0, 1'b1);
    idle();

    // Randomised traffic with a narrow address window for collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 1)), ra,
            $urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0);
    end
    wait_ready();

    // Reset in the middle of a clear: clear restarts from entry 0.
    wr(8'h03, 8'h5A, 1'b0);
    rd(8'h03);
    idle();
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (100) idle();
    apply_reset(3);
    wait_ready();
    rd(8'h03);
    idle();

    // Reset while a read is in flight.
    wr(8'h07, 8'h11, 1'b0);
    rd(8'h07);
    apply_reset(2);
    wait_ready();
    rd(8'h07);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
